// File: rtl/hamming_pkg.sv
// Shared definitions for the 16-bit / 11-data-bit SECDED Hamming code.
// Holds vector/data widths, the data-bit placement table, the scrubber state
// type and the syndrome helper used by both the encoder and the decoder.
package hamming_pkg;

    localparam int HV_W   = 16;
    localparam int DATA_W = 11;

    // Vector bit that carries data bit j; powers of two and bit 0 hold parity.
    localparam int DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    typedef enum logic [2:0] {
        SCRUB_IDLE  = 3'd0,
        SCRUB_READ  = 3'd1,
        SCRUB_CHECK = 3'd2,
        SCRUB_FIX   = 3'd3,
        SCRUB_NEXT  = 3'd4
    } scrub_state_t;

    // XOR of the indices of all set bits 15..1. On a data-only vector this
    // yields the four Hamming parity bits; on a stored vector it is the
    // syndrome (index of a single flipped bit).
    function automatic logic [3:0] hv_syndrome(input logic [HV_W-1:0] v);
        logic [3:0] s;
        s = '0;
        for (int i = 1; i < HV_W; i++) begin
            if (v[i]) begin
                s = s ^ 4'(i);
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/hamming16t11d_dec.sv
// Combinational SECDED decoder for the 16-bit Hamming vector.
// Ports:
//   code_i  in  16  stored vector
//   data_o  out 11  corrected data (uncorrected on a double error)
//   sec_o   out 1   single error detected and corrected
//   ded_o   out 1   double error detected, data passed through
module hamming16t11d_dec
    import hamming_pkg::*;
(
    input  logic [HV_W-1:0]   code_i,
    output logic [DATA_W-1:0] data_o,
    output logic              sec_o,
    output logic              ded_o
);

    logic [3:0]      syn;
    logic            par;
    logic [HV_W-1:0] fixed;

    assign syn = hv_syndrome(code_i);
    assign par = ^code_i;

    // Odd overall parity means one flipped bit at index syn; syn==0 points
    // at the overall parity bit itself, which carries no data.
    assign fixed = code_i ^ (HV_W'(par) << syn);

    always_comb begin
        data_o = '0;
        for (int j = 0; j < DATA_W; j++) begin
            data_o[j] = fixed[DATA_POS[j]];
        end
    end

    assign sec_o = par;
    assign ded_o = ~par & (syn != 4'd0);

endmodule

// File: rtl/hamming16t11d_enc.sv
// Combinational SECDED encoder: 11 data bits -> 16-bit Hamming vector.
// Ports:
//   data_i  in  11  data word
//   code_o  out 16  encoded vector (parity at 1,2,4,8; overall parity at 0)
module hamming16t11d_enc
    import hamming_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    output logic [HV_W-1:0]   code_o
);

    logic [HV_W-1:0] placed;
    logic [3:0]      par;

    always_comb begin
        placed = '0;
        for (int j = 0; j < DATA_W; j++) begin
            placed[DATA_POS[j]] = data_i[j];
        end
    end

    // Parity positions are still zero in placed, so its syndrome is exactly
    // the set of parity bits that makes the final syndrome zero.
    assign par = hv_syndrome(placed);

    always_comb begin
        code_o    = placed;
        code_o[1] = par[0];
        code_o[2] = par[1];
        code_o[4] = par[2];
        code_o[8] = par[3];
        code_o[0] = ^code_o[HV_W-1:1];
    end

endmodule

// File: rtl/hamming16t11d_scrub_mem.sv
// SECDED-protected register file with background scrubber.
// Words are encoded on write and decoded on read; a scrubber periodically
// walks all entries and rewrites words holding a correctable error.
// Ports:
//   clk_i, rstn_i                clock, asynchronous active-low reset
//   we_i, waddr_i, wdata_i       user write
//   re_i, raddr_i                user read request
//   rdata_o, rvalid_o            decoded read data, valid one cycle after re_i
//   rsec_o, rded_o               read word had single / double error
//   inj_i, inj_addr_i, inj_mask_i  XOR fault injection into a stored vector
//   scrub_busy_o                 scrubber not idle
//   sec_cnt_o, ded_cnt_o         saturating SEC / DED event counters
module hamming16t11d_scrub_mem
    import hamming_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int SCRUB_PERIOD = 256,
    parameter int CNT_W        = 16
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [10:0]              wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [10:0]              rdata_o,
    output logic                     rvalid_o,
    output logic                     rsec_o,
    output logic                     rded_o,
    input  logic                     inj_i,
    input  logic [$clog2(DEPTH)-1:0] inj_addr_i,
    input  logic [15:0]              inj_mask_i,
    output logic                     scrub_busy_o,
    output logic [CNT_W-1:0]         sec_cnt_o,
    output logic [CNT_W-1:0]         ded_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(SCRUB_PERIOD);

    logic [HV_W-1:0]   mem_q [DEPTH];

    scrub_state_t      state_q, state_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     period_q, period_d;
    logic [HV_W-1:0]   scrub_word_q, scrub_word_d;

    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q, rsec_q, rded_q;
    logic [CNT_W-1:0]  sec_cnt_q, ded_cnt_q;

    logic [HV_W-1:0]   rd_code, wr_code, fix_code;
    logic [DATA_W-1:0] rd_data, sc_data;
    logic              rd_sec, rd_ded, sc_sec, sc_ded;
    logic              sc_check, fix_we;

    assign rd_code = mem_q[raddr_i];

    hamming16t11d_dec u_rd_dec (
        .code_i (rd_code),
        .data_o (rd_data),
        .sec_o  (rd_sec),
        .ded_o  (rd_ded)
    );

    hamming16t11d_dec u_sc_dec (
        .code_i (scrub_word_q),
        .data_o (sc_data),
        .sec_o  (sc_sec),
        .ded_o  (sc_ded)
    );

    hamming16t11d_enc u_wr_enc (
        .data_i (wdata_i),
        .code_o (wr_code)
    );

    hamming16t11d_enc u_fix_enc (
        .data_i (sc_data),
        .code_o (fix_code)
    );

    assign sc_check = (state_q == SCRUB_CHECK);
    // A user write to the entry being repaired carries newer data.
    assign fix_we   = (state_q == SCRUB_FIX) && !(we_i && (waddr_i == ptr_q));

    // Later assignments win: user write over scrub repair over injection.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (inj_i) begin
                mem_q[inj_addr_i] <= mem_q[inj_addr_i] ^ inj_mask_i;
            end
            if (fix_we) begin
                mem_q[ptr_q] <= fix_code;
            end
            if (we_i) begin
                mem_q[waddr_i] <= wr_code;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        period_d     = period_q;
        scrub_word_d = scrub_word_q;
        unique case (state_q)
            SCRUB_IDLE: begin
                if (period_q == PW'(SCRUB_PERIOD - 1)) begin
                    // Only start when the user port is quiet; otherwise hold.
                    if (!we_i && !re_i) begin
                        state_d  = SCRUB_READ;
                        period_d = '0;
                    end
                end else begin
                    period_d = period_q + PW'(1);
                end
            end
            SCRUB_READ: begin
                scrub_word_d = mem_q[ptr_q];
                state_d      = SCRUB_CHECK;
            end
            SCRUB_CHECK: begin
                state_d = sc_sec ? SCRUB_FIX : SCRUB_NEXT;
            end
            SCRUB_FIX: begin
                state_d = SCRUB_NEXT;
            end
            SCRUB_NEXT: begin
                ptr_d   = ptr_q + AW'(1);
                state_d = SCRUB_IDLE;
            end
            default: begin
                state_d = SCRUB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= SCRUB_IDLE;
            ptr_q        <= '0;
            period_q     <= '0;
            scrub_word_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            period_q     <= period_d;
            scrub_word_q <= scrub_word_d;
        end
    end

    // Adds up to two events; the extra carry bit detects overflow.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic a, input logic b);
        logic [CNT_W+1:0] sum;
        sum = {2'b00, cnt} + {{(CNT_W+1){1'b0}}, a} + {{(CNT_W+1){1'b0}}, b};
        return (sum[CNT_W+1:CNT_W] != 2'b00) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            rsec_q    <= 1'b0;
            rded_q    <= 1'b0;
            sec_cnt_q <= '0;
            ded_cnt_q <= '0;
        end else begin
            rvalid_q  <= re_i;
            rdata_q   <= re_i ? rd_data : '0;
            rsec_q    <= re_i & rd_sec;
            rded_q    <= re_i & rd_ded;
            sec_cnt_q <= sat_add(sec_cnt_q, re_i & rd_sec, sc_check & sc_sec);
            ded_cnt_q <= sat_add(ded_cnt_q, re_i & rd_ded, sc_check & sc_ded);
        end
    end

    assign rdata_o      = rdata_q;
    assign rvalid_o     = rvalid_q;
    assign rsec_o       = rsec_q;
    assign rded_o       = rded_q;
    assign scrub_busy_o = (state_q != SCRUB_IDLE);
    assign sec_cnt_o    = sec_cnt_q;
    assign ded_cnt_o    = ded_cnt_q;

endmodule

// File: tb/tb_hamming16t11d_scrub_mem.sv
// Self-checking bench for hamming16t11d_scrub_mem. A behavioural model
// (arithmetic Hamming code, per-cycle scrub walk) predicts every output.
// A second instance with 2-bit counters shares all stimulus.
module tb_hamming16t11d_scrub_mem;

    localparam int DEPTH = 8;
    localparam int SP    = 16;
    localparam int DPOS [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
    localparam int PH_IDLE = 0, PH_READ = 1, PH_CHECK = 2, PH_FIX = 3, PH_NEXT = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        we, re, inj;
    logic [2:0]  waddr, raddr, inj_addr;
    logic [10:0] wdata;
    logic [15:0] inj_mask;

    logic [10:0] rdata, d2_rdata;
    logic        rvalid, rsec, rded, busy;
    logic        d2_rvalid, d2_rsec, d2_rded, d2_busy;
    logic [15:0] sec_cnt, ded_cnt;
    logic [1:0]  d2_sec_cnt, d2_ded_cnt;

    int checks = 0;
    int passes = 0;

    // model state
    logic [15:0] m_mem [DEPTH];
    logic [15:0] m_sword;
    int          m_phase, m_wait, m_ptr, m_sec, m_ded;
    logic        m_rvalid, m_rsec, m_rded;
    logic [10:0] m_rdata;

    always #5 clk = ~clk;

    hamming16t11d_scrub_mem #(.DEPTH(DEPTH), .SCRUB_PERIOD(SP), .CNT_W(16)) dut (
        .clk_i(clk), .rstn_i(rstn), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .re_i(re), .raddr_i(raddr), .rdata_o(rdata), .rvalid_o(rvalid),
        .rsec_o(rsec), .rded_o(rded), .inj_i(inj), .inj_addr_i(inj_addr),
        .inj_mask_i(inj_mask), .scrub_busy_o(busy), .sec_cnt_o(sec_cnt),
        .ded_cnt_o(ded_cnt));

    hamming16t11d_scrub_mem #(.DEPTH(DEPTH), .SCRUB_PERIOD(SP), .CNT_W(2)) dut2 (
        .clk_i(clk), .rstn_i(rstn), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .re_i(re), .raddr_i(raddr), .rdata_o(d2_rdata), .rvalid_o(d2_rvalid),
        .rsec_o(d2_rsec), .rded_o(d2_rded), .inj_i(inj), .inj_addr_i(inj_addr),
        .inj_mask_i(inj_mask), .scrub_busy_o(d2_busy), .sec_cnt_o(d2_sec_cnt),
        .ded_cnt_o(d2_ded_cnt));

    function automatic int sat(input int v, input int w);
        return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
    endfunction

    function automatic logic [15:0] ref_enc(input logic [10:0] d);
        logic [15:0] v;
        int n;
        v = '0;
        for (int j = 0; j < 11; j++) v[DPOS[j]] = d[j];
        for (int k = 0; k < 4; k++) begin
            n = 0;
            for (int i = 1; i < 16; i++) if (((i >> k) & 1) == 1 && v[i]) n++;
            v[1 << k] = (n % 2) == 1;
        end
        v[0] = ($countones(v[15:1]) % 2) == 1;
        return v;
    endfunction

    function automatic void ref_dec(input logic [15:0] v, output logic [10:0] d,
                                    output logic sec, output logic ded);
        int s;
        int n;
        logic [15:0] c;
        s = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            for (int i = 1; i < 16; i++) if (((i >> k) & 1) == 1 && v[i]) n++;
            if (n % 2 == 1) s += (1 << k);
        end
        sec = ($countones(v) % 2) == 1;
        ded = !sec && s != 0;
        c = v;
        if (sec) c[s] = ~c[s];
        for (int j = 0; j < 11; j++) d[j] = c[DPOS[j]];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_sword = '0; m_phase = PH_IDLE; m_wait = 0; m_ptr = 0;
        m_sec = 0; m_ded = 0; m_rvalid = 0; m_rsec = 0; m_rded = 0; m_rdata = '0;
    endtask

    // One clock edge of the reference: everything reads pre-edge memory.
    task automatic model_step();
        logic [15:0] nm [DEPTH];
        logic [10:0] d;
        logic        se, de, fix_en;
        logic [15:0] fix_v;
        nm = m_mem; fix_en = 0; fix_v = '0;
        m_rvalid = re; m_rdata = '0; m_rsec = 0; m_rded = 0;
        if (re) begin
            ref_dec(m_mem[raddr], d, se, de);
            m_rdata = d; m_rsec = se; m_rded = de;
            if (se) m_sec++;
            if (de) m_ded++;
        end
        case (m_phase)
            PH_IDLE: begin
                if (m_wait == SP - 1) begin
                    if (!we && !re) begin m_phase = PH_READ; m_wait = 0; end
                end else m_wait++;
            end
            PH_READ: begin m_sword = m_mem[m_ptr]; m_phase = PH_CHECK; end
            PH_CHECK: begin
                ref_dec(m_sword, d, se, de);
                if (se) m_sec++;
                if (de) m_ded++;
                m_phase = se ? PH_FIX : PH_NEXT;
            end
            PH_FIX: begin
                ref_dec(m_sword, d, se, de);
                if (!(we && waddr == m_ptr)) begin fix_en = 1; fix_v = ref_enc(d); end
                m_phase = PH_NEXT;
            end
            default: begin m_ptr = (m_ptr + 1) % DEPTH; m_phase = PH_IDLE; end
        endcase
        if (inj) nm[inj_addr] = nm[inj_addr] ^ inj_mask;
        if (fix_en) nm[m_ptr] = fix_v;
        if (we) nm[waddr] = ref_enc(wdata);
        m_mem = nm;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        we = 0; re = 0; inj = 0; waddr = '0; raddr = '0; inj_addr = '0;
        wdata = '0; inj_mask = '0;
    endtask

    task automatic test_reset();
        rstn = 0; idle_inputs(); model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rvalid !== 1'b0) $display("FAIL reset_rvalid got %0b exp 0", rvalid); else passes++;
        checks++; if (rdata !== 11'h0) $display("FAIL reset_rdata got %h exp 0", rdata); else passes++;
        checks++; if (sec_cnt !== 16'h0 || ded_cnt !== 16'h0) $display("FAIL reset_cnt got %0d/%0d exp 0/0", sec_cnt, ded_cnt); else passes++;
        checks++; if (busy !== 1'b0 || d2_busy !== 1'b0) $display("FAIL reset_busy got %0b exp 0", busy); else passes++;
        rstn = 1;
        re = 1; raddr = 3'd3;
        tick();
        re = 0;
        checks++; if (rvalid !== 1'b1) $display("FAIL read0_rvalid got %0b exp 1", rvalid); else passes++;
        checks++; if (rdata !== 11'h0 || rsec !== 1'b0 || rded !== 1'b0)
            $display("FAIL read0_data got %h sec %0b ded %0b exp 0 0 0", rdata, rsec, rded); else passes++;
        tick();
        checks++; if (rvalid !== 1'b0) $display("FAIL read0_rvalid_drop got %0b exp 0", rvalid); else passes++;
    endtask

    task automatic test_sec_read();
        we = 1; waddr = 3'd2; wdata = 11'h5A5;
        tick();
        we = 0; inj = 1; inj_addr = 3'd2; inj_mask = 16'h0400;
        tick();
        inj = 0; re = 1; raddr = 3'd2;
        tick();
        re = 0;
        checks++; if (rdata !== 11'h5A5) $display("FAIL sec_rdata got %h exp 5a5", rdata); else passes++;
        checks++; if (rsec !== 1'b1 || rded !== 1'b0) $display("FAIL sec_flags got sec %0b ded %0b exp 1 0", rsec, rded); else passes++;
        checks++; if (sec_cnt !== 16'(sat(m_sec, 16))) $display("FAIL sec_cnt got %0d exp %0d", sec_cnt, sat(m_sec, 16)); else passes++;
        checks++; if (sec_cnt !== 16'd1) $display("FAIL sec_cnt_first got %0d exp 1", sec_cnt); else passes++;
    endtask

    task automatic test_ded_read();
        inj = 1; inj_addr = 3'd1; inj_mask = 16'h0003;
        tick();
        inj = 0; re = 1; raddr = 3'd1;
        tick();
        re = 0;
        checks++; if (rded !== 1'b1 || rsec !== 1'b0) $display("FAIL ded_flags got sec %0b ded %0b exp 0 1", rsec, rded); else passes++;
        checks++; if (ded_cnt !== 16'(sat(m_ded, 16)) || ded_cnt === 16'd0) $display("FAIL ded_cnt got %0d exp %0d", ded_cnt, m_ded); else passes++;
        repeat (DEPTH * (SP + 5) + 10) tick();
        re = 1; raddr = 3'd1;
        tick();
        re = 0;
        checks++; if (rded !== 1'b1 || rdata !== 11'h0) $display("FAIL ded_after_scrub got ded %0b data %h exp 1 000", rded, rdata); else passes++;
        checks++; if (ded_cnt !== 16'(sat(m_ded, 16))) $display("FAIL ded_cnt_scrub got %0d exp %0d", ded_cnt, m_ded); else passes++;
        checks++; if (d2_ded_cnt !== 2'(sat(m_ded, 2))) $display("FAIL d2_ded_cnt got %0d exp %0d", d2_ded_cnt, sat(m_ded, 2)); else passes++;
        we = 1; waddr = 3'd1; wdata = 11'h0;
        tick();
        we = 0;
    endtask

    task automatic test_scrub_fix();
        logic [10:0] d;
        int sec_before;
        d = 11'($urandom);
        we = 1; waddr = 3'd5; wdata = d;
        tick();
        we = 0; inj = 1; inj_addr = 3'd5; inj_mask = 16'h8000;
        tick();
        inj = 0;
        sec_before = m_sec;
        repeat (DEPTH * (SP + 5) + 10) tick();
        checks++; if (sec_cnt < 16'(sec_before + 1) || sec_cnt !== 16'(sat(m_sec, 16)))
            $display("FAIL scrub_sec_cnt got %0d exp %0d", sec_cnt, m_sec); else passes++;
        re = 1; raddr = 3'd5;
        tick();
        re = 0;
        checks++; if (rdata !== d) $display("FAIL scrub_rdata got %h exp %h", rdata, d); else passes++;
        checks++; if (rsec !== 1'b0 || rded !== 1'b0) $display("FAIL scrub_clean got sec %0b ded %0b exp 0 0", rsec, rded); else passes++;
    endtask

    task automatic test_fix_collision();
        int target;
        logic [10:0] d;
        int n;
        n = 0;
        while (m_phase != PH_IDLE && n < 10) begin tick(); n++; end
        target = m_ptr;
        inj = 1; inj_addr = 3'(target); inj_mask = 16'h0010;
        tick();
        inj = 0;
        n = 0;
        while (m_phase != PH_FIX && n < SP + 10) begin tick(); n++; end
        checks++; if (m_phase != PH_FIX || busy !== 1'b1)
            $display("FAIL fix_wait got busy %0b exp scrub FIX within %0d cycles", busy, SP + 10); else passes++;
        d = 11'($urandom);
        we = 1; waddr = 3'(target); wdata = d;
        tick();
        we = 0; re = 1; raddr = 3'(target);
        tick();
        re = 0;
        checks++; if (rdata !== d || rsec !== 1'b0) $display("FAIL fix_collide got %h sec %0b exp %h 0", rdata, rsec, d); else passes++;
        checks++; if (sec_cnt !== 16'(sat(m_sec, 16))) $display("FAIL fix_sec_cnt got %0d exp %0d", sec_cnt, m_sec); else passes++;
    endtask

    task automatic test_saturation();
        inj = 1; inj_addr = 3'd6; inj_mask = 16'h0001;
        tick();
        inj = 0; re = 1; raddr = 3'd6;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (rvalid !== 1'b1 || rsec !== 1'b1 || rdata !== m_rdata)
                $display("FAIL b2b_read%0d got v %0b sec %0b %h exp 1 1 %h", i, rvalid, rsec, rdata, m_rdata); else passes++;
        end
        re = 0;
        tick();
        checks++; if (d2_sec_cnt !== 2'b11) $display("FAIL sat_sec_cnt got %0d exp 3", d2_sec_cnt); else passes++;
        checks++; if (sec_cnt !== 16'(sat(m_sec, 16))) $display("FAIL wide_sec_cnt got %0d exp %0d", sec_cnt, m_sec); else passes++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            we = ($urandom_range(0, 3) == 0); waddr = 3'($urandom); wdata = 11'($urandom);
            re = ($urandom_range(0, 2) == 0); raddr = 3'($urandom);
            inj = ($urandom_range(0, 5) == 0); inj_addr = 3'($urandom);
            inj_mask = (16'h1 << $urandom_range(0, 15)) |
                       (($urandom_range(0, 2) == 0) ? (16'h1 << $urandom_range(0, 15)) : 16'h0);
            tick();
            checks++; if (rvalid !== m_rvalid) $display("FAIL rnd_rvalid c%0d got %0b exp %0b", c, rvalid, m_rvalid); else passes++;
            if (m_rvalid) begin
                checks++; if (rdata !== m_rdata || rsec !== m_rsec || rded !== m_rded)
                    $display("FAIL rnd_read c%0d got %h %0b %0b exp %h %0b %0b", c, rdata, rsec, rded, m_rdata, m_rsec, m_rded); else passes++;
            end
            checks++; if (sec_cnt !== 16'(sat(m_sec, 16)) || ded_cnt !== 16'(sat(m_ded, 16)))
                $display("FAIL rnd_cnt c%0d got %0d/%0d exp %0d/%0d", c, sec_cnt, ded_cnt, m_sec, m_ded); else passes++;
            checks++; if (d2_sec_cnt !== 2'(sat(m_sec, 2)) || d2_ded_cnt !== 2'(sat(m_ded, 2)))
                $display("FAIL rnd_cnt2 c%0d got %0d/%0d exp %0d/%0d", c, d2_sec_cnt, d2_ded_cnt, sat(m_sec, 2), sat(m_ded, 2)); else passes++;
            checks++; if (busy !== (m_phase != PH_IDLE)) $display("FAIL rnd_busy c%0d got %0b exp %0b", c, busy, m_phase != PH_IDLE); else passes++;
        end
        idle_inputs();
    endtask

    task automatic test_reset_midscrub();
        logic [2:0] a;
        int n;
        n = 0;
        while (m_phase == PH_IDLE && n < 2 * SP + 10) begin tick(); n++; end
        checks++; if (busy !== 1'b1) $display("FAIL midscrub_busy got %0b exp 1", busy); else passes++;
        #2 rstn = 0;
        #1;
        checks++; if (busy !== 1'b0 || sec_cnt !== 16'h0 || ded_cnt !== 16'h0)
            $display("FAIL async_reset got busy %0b cnt %0d/%0d exp 0 0/0", busy, sec_cnt, ded_cnt); else passes++;
        model_reset();
        @(negedge clk);
        rstn = 1;
        a = 3'($urandom);
        re = 1; raddr = a;
        tick();
        re = 0;
        checks++; if (rvalid !== 1'b1 || rdata !== 11'h0 || rsec !== 1'b0 || rded !== 1'b0)
            $display("FAIL post_reset_read got v %0b %h %0b %0b exp 1 000 0 0", rvalid, rdata, rsec, rded); else passes++;
    endtask

    initial begin
        test_reset();
        test_sec_read();
        test_ded_read();
        test_scrub_fix();
        test_fix_collision();
        test_saturation();
        test_random();
        test_reset_midscrub();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
